// File: rtl/dma_axis2axi4_s2mm_burst.sv
// AXIS -> AXI4 S2MM DMA: FIFO-buffered INCR bursts into a [min,max) window.
// Define DMA_S2MM_4K_SPLIT_EN to stop bursts crossing 4 KB boundaries.
module dma_axis2axi4_s2mm_burst #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 24,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [ADDR_W-1:0]            min_addr,
  input  logic [ADDR_W-1:0]            max_addr,
  input  logic [LEN_W-1:0]             len,
  input  logic                         flush,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [ADDR_W-1:0]            cur_addr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
  input  logic [DATA_W-1:0]            s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [ADDR_W-1:0]            m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_W-1:0]            m_axi_wdata,
  output logic [DATA_W/8-1:0]          m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BL_W  = $clog2(MAX_BURST) + 1;
  localparam int WW    = (ADDR_W > LEN_W ? ADDR_W : LEN_W) + 1;
  localparam logic [BL_W-1:0] ONE = BL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_W, S_B
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt;
  logic              full, empty, flush_now, wr, rd;

  logic              mode_q;
  logic [ADDR_W-1:0] min_q, max_q;
  logic [LEN_W-1:0]  rem;
  logic [BL_W-1:0]   blen, blen_c, beat;

  assign full      = cnt == CW'(FIFO_DEPTH);
  assign empty     = cnt == '0;
  assign flush_now = flush && (state == S_IDLE);
  assign wr        = s_axis_tvalid && s_axis_tready;
  assign rd        = m_axi_wvalid && m_axi_wready;

  assign s_axis_tready = !full && !flush_now;
  assign fifo_cnt      = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= s_axis_tdata;
  end

  // Burst length: smallest of the burst cap, the remaining beats and
  // the room left before max_addr (and the 4 KB page when enabled).
  logic [WW-1:0] win_w, rem_w, bl_c;
`ifdef DMA_S2MM_4K_SPLIT_EN
  logic [12:0]   k4_bytes;
  logic [WW-1:0] k4_w;
  assign k4_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
  assign k4_w     = WW'(k4_bytes >> SZ);
`endif

  assign win_w = WW'((max_q - cur_addr) >> SZ);
  assign rem_w = WW'(rem);

  always_comb begin
    bl_c = WW'(MAX_BURST);
    if (rem_w < bl_c) bl_c = rem_w;
    if (win_w < bl_c) bl_c = win_w;
`ifdef DMA_S2MM_4K_SPLIT_EN
    if (k4_w < bl_c) bl_c = k4_w;
`endif
  end

  assign blen_c = BL_W'(bl_c);

  logic              b_fire, b_err, at_max;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  next_rem;

  assign b_fire    = m_axi_bvalid && m_axi_bready;
  assign b_err     = m_axi_bresp != 2'b00;
  assign next_addr = cur_addr + (ADDR_W'(blen) << SZ);
  assign next_rem  = rem - LEN_W'(blen);
  assign at_max    = next_addr == max_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start && len != '0) state_nx = S_CALC;
      S_CALC: if (cnt >= CW'(blen_c)) state_nx = S_AW;
      S_AW:   if (m_axi_awready) state_nx = S_W;
      S_W:    if (rd && m_axi_wlast) state_nx = S_B;
      S_B: begin
        if (b_fire) begin
          if (b_err || next_rem == '0) state_nx = S_IDLE;
          else if (at_max && !mode_q)  state_nx = S_IDLE;
          else                         state_nx = S_CALC;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      min_q    <= '0;
      max_q    <= '0;
      cur_addr <= '0;
      rem      <= '0;
      blen     <= '0;
      beat     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            min_q    <= min_addr;
            max_q    <= max_addr;
            cur_addr <= min_addr;
            rem      <= len;
            err      <= 1'b0;
            if (len == '0) done <= 1'b1;
            else           busy <= 1'b1;
          end
        end
        S_CALC: begin
          blen <= blen_c;
          beat <= '0;
        end
        S_W: if (rd) beat <= beat + ONE;
        S_B: begin
          if (b_fire) begin
            if (b_err) begin
              err  <= 1'b1;
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              cur_addr <= next_addr;
              rem      <= next_rem;
              if (next_rem == '0) begin
                done <= 1'b1;
                busy <= 1'b0;
              end else if (at_max) begin
                if (mode_q) begin
                  cur_addr <= min_q;
                end else begin
                  err  <= 1'b1;
                  done <= 1'b1;
                  busy <= 1'b0;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awvalid = state == S_AW;
  assign m_axi_awaddr  = m_axi_awvalid ? cur_addr : '0;
  assign m_axi_awlen   = m_axi_awvalid ? 8'(blen - ONE) : 8'd0;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;

  assign m_axi_wvalid = (state == S_W) && !empty;
  assign m_axi_wdata  = m_axi_wvalid ? mem[rptr] : '0;
  assign m_axi_wstrb  = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast  = m_axi_wvalid && (beat == blen - ONE);

  assign m_axi_bready = state == S_B;

endmodule

// File: tb/tb_dma_axis2axi4_s2mm_burst.sv
// Scoreboard bench for dma_axis2axi4_s2mm_burst: directed transfers,
// queue-based AW/W/done checking, slave responder with error injection.
module tb_dma_axis2axi4_s2mm_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mode = 1'b0, flush = 1'b0;
  logic [31:0] min_addr = '0, max_addr = '0;
  logic [23:0] len = '0;
  logic        busy, done, err;
  logic [31:0] cur_addr;
  logic [5:0]  fifo_cnt;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0, tready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready = 1'b1;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  always #5 clk = ~clk;

  dma_axis2axi4_s2mm_burst dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .min_addr(min_addr), .max_addr(max_addr), .len(len),
    .flush(flush), .busy(busy), .done(done), .err(err),
    .cur_addr(cur_addr), .fifo_cnt(fifo_cnt),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  aw_t         aq[$];
  logic [63:0] wq[$];
  logic        dq[$];
  int          total = 0, bad = 0;
  int          done_cnt = 0, ndone = 0;
  logic        slverr_next = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake
  initial begin
    aw_t e;
    int  beat = 0, blen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awvalid && awready) begin
          if (aq.size() == 0) miss("aw_unexpected");
          else begin
            e = aq.pop_front();
            chk("aw_addr", awaddr, e.addr);
            chk("aw_len", awlen, e.len);
            blen = int'(e.len) + 1;
            beat = 0;
          end
        end
        if (wvalid && wready) begin
          chk("w_strb", wstrb, 8'hFF);
          if (wq.size() == 0) miss("w_unexpected");
          else chk("w_data", wdata, wq.pop_front());
          chk("w_last", wlast, beat == blen - 1);
          beat++;
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", busy, 0);
          if (dq.size() == 0) miss("done_unexpected");
          else chk("done_err", err, dq.pop_front());
        end
      end
    end
  end

  // AXI slave write-response channel
  initial begin
    logic fb, fl;
    forever begin
      @(negedge clk);
      fb = bvalid && bready;
      fl = wvalid && wready && wlast;
      @(posedge clk);
      #1;
      if (rst) bvalid = 1'b0;
      else begin
        if (fb) bvalid = 1'b0;
        if (fl) begin
          bvalid = 1'b1;
          bresp = slverr_next ? 2'b10 : 2'b00;
          slverr_next = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int n, logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      int to = 0;
      tdata = base + 64'(i);
      tvalid = 1'b1;
      @(negedge clk);
      while (!tready && to < 2000) begin
        @(negedge clk);
        to++;
      end
      if (!tready) begin
        chk("send_timeout", tready, 1);
        tvalid = 1'b0;
        return;
      end
      wq.push_back(tdata);
      tick();
    end
    tvalid = 1'b0;
  endtask

  task automatic push_aw(logic [31:0] a, logic [7:0] l);
    aw_t e;
    e.addr = a;
    e.len = l;
    aq.push_back(e);
  endtask

  task automatic do_start(logic m, logic [31:0] lo, logic [31:0] hi,
                          logic [23:0] n, logic exp_err, bit lat);
    mode = m;
    min_addr = lo;
    max_addr = hi;
    len = n;
    start = 1'b1;
    dq.push_back(exp_err);
    tick();
    start = 1'b0;
    if (lat) begin
      chk("lat_cycle1", awvalid, 0);
      tick();
      chk("lat_cycle2", awvalid, 1);
    end
  endtask

  task automatic wait_done();
    int to = 0;
    ndone++;
    while (done_cnt < ndone && to < 5000) begin
      @(posedge clk);
      to++;
    end
    #1;
    chk("done_seen", done_cnt, ndone);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cnt", fifo_cnt, 0);
    wq.delete();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_fifo", fifo_cnt, 0);
    chk("rst_awsize", awsize, 3);
    chk("rst_awburst", awburst, 1);
    chk("rst_cur", cur_addr, 0);

    // zero-length transfer
    do_start(0, 32'h1000, 32'h2000, 0, 0, 0);
    chk("len0_done", done, 1);
    chk("len0_aw", awvalid, 0);
    wait_done();

    // DIRECT 40 beats, 16 prefetched
    send(16, 64'h100);
    chk("prefetch_cnt", fifo_cnt, 16);
    push_aw(32'h1000, 15);
    push_aw(32'h1080, 15);
    push_aw(32'h1100, 7);
    do_start(0, 32'h1000, 32'h2000, 40, 0, 1);
    send(24, 64'h110);
    wait_done();
    chk("t1_err", err, 0);
    chk("t1_aw_left", aq.size(), 0);
    chk("t1_cur", cur_addr, 32'h1140);
    chk("t1_fifo", fifo_cnt, 0);

    // CIRCULAR wrap
    push_aw(32'h0, 15);
    push_aw(32'h80, 15);
    push_aw(32'h0, 15);
    push_aw(32'h80, 15);
    do_start(1, 32'h0, 32'h100, 64, 0, 0);
    send(64, 64'h200);
    wait_done();
    chk("t2_err", err, 0);
    chk("t2_aw_left", aq.size(), 0);

    // DIRECT window overrun
    push_aw(32'h0, 7);
    do_start(0, 32'h0, 32'h40, 10, 1, 0);
    send(10, 64'h300);
    wait_done();
    repeat (5) tick();
    chk("t3_err", err, 1);
    chk("t3_aw_left", aq.size(), 0);
    chk("t3_fifo", fifo_cnt, 2);
    do_flush();

    // SLVERR on first burst
    slverr_next = 1'b1;
    push_aw(32'h0, 15);
    do_start(0, 32'h0, 32'h1000, 48, 1, 0);
    send(48, 64'h400);
    wait_done();
    repeat (5) tick();
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_fifo", fifo_cnt, 32);
    chk("t4_aw_left", aq.size(), 0);
    do_flush();

    // 4 KB straddling window, err cleared by start
    push_aw(32'hF80, 15);
    push_aw(32'h1000, 15);
    do_start(0, 32'hF80, 32'h2000, 32, 0, 0);
    chk("t5_err_clr", err, 0);
    send(32, 64'h500);
    wait_done();
    chk("t5_err", err, 0);
    chk("t5_aw_left", aq.size(), 0);

    // FIFO fill to full, then flush
    wready = 1'b0;
    tvalid = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tdata = 64'hF00 + 64'(i);
      @(negedge clk);
      if (!tready) break;
      tick();
      n++;
    end
    chk("fill_n", n, 32);
    chk("fill_cnt", fifo_cnt, 32);
    chk("fill_tready", tready, 0);
    tvalid = 1'b0;
    do_flush();

    // reset in the middle of a stalled W burst
    push_aw(32'h0, 15);
    do_start(0, 32'h0, 32'h1000, 16, 0, 0);
    send(16, 64'h600);
    n = 0;
    while (aq.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    tick();
    chk("t6_in_w", wvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_bready", bready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fifo", fifo_cnt, 0);
    wq.delete();
    dq.delete();
    wready = 1'b1;

    push_aw(32'h2000, 15);
    do_start(0, 32'h2000, 32'h3000, 16, 0, 0);
    send(16, 64'h700);
    wait_done();
    chk("t7_err", err, 0);
    chk("t7_aw_left", aq.size(), 0);
    chk("t7_w_left", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
